branch_predict_unit: RTL and testbench

//  Parametrised successor to the single-cycle branch resolver. Adds a direct-mapped

---
 rtl/branch_predict_unit.sv | 143 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with saturating direction counters,
// single-cycle resolve/redirect in Execute, and branch/mispredict statistics.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   F_PC,
    output logic              F_PredTaken,
    output logic [31:0]       F_PredTarget,
    input  logic              E_Valid,
    input  logic [PC_W-1:0]   E_PC,
    input  logic [31:0]       E_Imm,
    input  logic              E_Branch,
    input  logic              E_Jal,
    input  logic              E_Jalr,
    input  logic [31:0]       E_AluResult,
    input  logic              E_PredTaken,
    input  logic [31:0]       E_PredTarget,
    output logic [31:0]       PC_Imm,
    output logic [31:0]       PC_Four,
    output logic [31:0]       BrPC,
    output logic              PcSel,
    output logic [STAT_W-1:0] BrCount,
    output logic [STAT_W-1:0] MissCount
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_MAX >> 1;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_INIT + 1'b1;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [CNT_W-1:0] cnt_d    [ENTRIES];
    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] miss_count_q, miss_count_d;

    // Fetch lookup; the two byte-offset bits of the PC never select an entry.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [1:0]       unused_f_pc;

    assign f_idx        = F_PC[IDX_W+1:2];
    assign f_tag        = F_PC[PC_W-1:IDX_W+2];
    assign unused_f_pc  = F_PC[1:0];
    assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign F_PredTaken  = f_hit & cnt_q[f_idx][CNT_W-1];
    assign F_PredTarget = F_PredTaken ? {{(32-PC_W){1'b0}}, target_q[f_idx]} : 32'd0;

    // Execute resolve
    logic [31:0]      pc_ext;
    logic [31:0]      e_tgt;
    logic             e_ctl;
    logic             e_taken;
    logic             e_mispredict;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;

    assign pc_ext    = {{(32-PC_W){1'b0}}, E_PC};
    assign PC_Imm    = pc_ext + E_Imm;
    assign PC_Four   = pc_ext + 32'd4;
    assign e_ctl     = E_Valid & (E_Branch | E_Jal | E_Jalr);
    assign e_taken   = E_Jal | E_Jalr | (E_Branch & E_AluResult[0]);
    assign e_tgt     = E_Jalr ? {E_AluResult[31:1], 1'b0} : PC_Imm;
    // A predicted-taken non-control instruction is an alias hit and must be undone.
    assign e_mispredict = E_Valid & ((e_ctl & e_taken)
                          ? (!E_PredTaken | (E_PredTarget != e_tgt))
                          : E_PredTaken);
    assign PcSel     = e_mispredict;
    assign BrPC      = e_mispredict ? (e_taken ? e_tgt : PC_Four) : 32'd0;

    assign e_idx     = E_PC[IDX_W+1:2];
    assign e_tag     = E_PC[PC_W-1:IDX_W+2];
    assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            cnt_d[i]    = cnt_q[i];
        end
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;

        if (e_ctl) begin
            if (e_hit) begin
                if (e_taken) begin
                    if (cnt_q[e_idx] != CNT_MAX) cnt_d[e_idx] = cnt_q[e_idx] + 1'b1;
                    target_d[e_idx] = e_tgt[PC_W-1:0];
                end else if (cnt_q[e_idx] != '0) begin
                    cnt_d[e_idx] = cnt_q[e_idx] - 1'b1;
                end
            end else if (e_taken) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = e_tgt[PC_W-1:0];
                cnt_d[e_idx]    = CNT_ALLOC;
            end
            if (br_count_q != '1) br_count_d = br_count_q + 1'b1;
        end else if (E_Valid && E_PredTaken) begin
            valid_d[e_idx] = 1'b0;
        end

        if (e_mispredict && (miss_count_q != '1)) miss_count_d = miss_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign BrCount   = br_count_q;
    assign MissCount = miss_count_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the BTB and statistics.
module tb_branch_predict_unit;
  localparam int NENT    = 16;
  localparam int CMAX    = 3;
  localparam int STATMAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  F_PC, E_PC;
  logic        F_PredTaken, PcSel;
  logic [31:0] F_PredTarget, E_Imm, E_AluResult, E_PredTarget;
  logic [31:0] PC_Imm, PC_Four, BrPC;
  logic        E_Valid, E_Branch, E_Jal, E_Jalr, E_PredTaken;
  logic [15:0] BrCount, MissCount;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .F_PredTaken(F_PredTaken),
    .F_PredTarget(F_PredTarget), .E_Valid(E_Valid), .E_PC(E_PC), .E_Imm(E_Imm),
    .E_Branch(E_Branch), .E_Jal(E_Jal), .E_Jalr(E_Jalr), .E_AluResult(E_AluResult),
    .E_PredTaken(E_PredTaken), .E_PredTarget(E_PredTarget), .PC_Imm(PC_Imm),
    .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel), .BrCount(BrCount),
    .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  // Expected {MissCount, BrCount} for each upcoming cycle.
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference table, indexed by PC/4 mod NENT, tag = PC/64.
  bit          m_valid[NENT];
  int unsigned m_tag[NENT];
  int unsigned m_tgt[NENT];
  int unsigned m_cnt[NENT];
  int unsigned m_br, m_miss;

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_miss = 0;
    exp_q.delete();
    exp_q.push_back(32'd0);
  endtask

  function automatic bit model_hit(input int unsigned pc);
    int unsigned idx;
    idx = (pc / 4) % NENT;
    return m_valid[idx] && (m_tag[idx] == pc / 64);
  endfunction

  task automatic predict(input int unsigned pc, output bit tk, output logic [31:0] tgt);
    tk  = model_hit(pc) && (m_cnt[(pc / 4) % NENT] >= 2);
    tgt = tk ? 32'(m_tgt[(pc / 4) % NENT]) : 32'd0;
  endtask

  task automatic drive(input bit rst, input bit v, input bit br, input bit jal, input bit jalr,
                       input int unsigned pc, input logic [31:0] imm, input logic [31:0] alu,
                       input bit pt, input logic [31:0] ptgt, input int unsigned fpc);
    @(negedge clk);
    reset = rst; E_Valid = v; E_Branch = br; E_Jal = jal; E_Jalr = jalr;
    E_PC = 9'(pc); E_Imm = imm; E_AluResult = alu; E_PredTaken = pt;
    E_PredTarget = ptgt; F_PC = 9'(fpc);
  endtask

  // Compare all outputs against the model, then advance the model past the next edge.
  task automatic settle_check();
    bit ptk, ctl, tk, mis, hit;
    logic [31:0] ptg, pimm, p4, tgt, brpc, stats;
    int unsigned pc, idx;
    #1;
    predict(F_PC, ptk, ptg);
    pc   = E_PC;
    pimm = 32'(pc) + E_Imm;
    p4   = 32'(pc) + 32'd4;
    ctl  = E_Valid && (E_Branch || E_Jal || E_Jalr);
    tk   = E_Jal || E_Jalr || (E_Branch && E_AluResult[0]);
    tgt  = E_Jalr ? (E_AluResult & 32'hFFFF_FFFE) : pimm;
    if (!E_Valid) mis = 0;
    else if (ctl && tk) mis = !E_PredTaken || (E_PredTarget != tgt);
    else mis = E_PredTaken;
    brpc  = mis ? (tk ? tgt : p4) : 32'd0;
    stats = exp_q.pop_front();
    check("pred_taken", 32'(F_PredTaken), 32'(ptk));
    check("pred_target", F_PredTarget, ptg);
    check("pc_imm", PC_Imm, pimm);
    check("pc_four", PC_Four, p4);
    check("pcsel", 32'(PcSel), 32'(mis));
    check("brpc", BrPC, brpc);
    check("br_count", 32'(BrCount), 32'(stats[15:0]));
    check("miss_count", 32'(MissCount), 32'(stats[31:16]));
    if (reset) begin
      model_reset();
    end else begin
      idx = (pc / 4) % NENT;
      hit = model_hit(pc);
      if (ctl) begin
        if (hit) begin
          if (tk) begin
            if (m_cnt[idx] < CMAX) m_cnt[idx]++;
            m_tgt[idx] = tgt % 512;
          end else if (m_cnt[idx] > 0) begin
            m_cnt[idx]--;
          end
        end else if (tk) begin
          m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt % 512; m_cnt[idx] = 2;
        end
        if (m_br < STATMAX) m_br++;
      end else if (E_Valid && E_PredTaken) begin
        m_valid[idx] = 0;
      end
      if (mis && m_miss < STATMAX) m_miss++;
      exp_q.push_back({16'(m_miss), 16'(m_br)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic idle(input int unsigned fpc);
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0, fpc);
    settle_check();
  endtask

  bit          r_pt;
  logic [31:0] r_ptgt, r_imm, r_alu;
  int unsigned r_pc, r_kind, r_fpc;

  initial begin
    reset = 1'b1; E_Valid = 0; E_Branch = 0; E_Jal = 0; E_Jalr = 0; E_PC = '0;
    E_Imm = '0; E_AluResult = '0; E_PredTaken = 0; E_PredTarget = '0; F_PC = '0;
    @(posedge clk);
    model_reset();

    // Out of reset: nothing predicted, counters clear.
    drive(1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 'h40);
    settle_check();
    check("rst_pred", 32'(F_PredTaken), 32'd0);
    check("rst_target", F_PredTarget, 32'd0);
    tick();

    // Cold taken branch mispredicts and allocates.
    drive(0, 1, 1, 0, 0, 'h40, 32'h20, 32'd1, 0, 32'd0, 'h0);
    settle_check();
    check("cold_pcsel", 32'(PcSel), 32'd1);
    check("cold_brpc", BrPC, 32'h60);
    tick();
    idle('h40);
    check("alloc_pred", 32'(F_PredTaken), 32'd1);
    check("alloc_target", F_PredTarget, 32'h60);
    check("alloc_miss", 32'(MissCount), 32'd1);
    tick();

    // Correctly predicted repeats train the counter up to saturation.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 'h40, 32'h20, 32'd1, 1, 32'h60, 'h40);
      settle_check();
      check("hit_pcsel", 32'(PcSel), 32'd0);
      tick();
    end

    // Two not-taken outcomes walk a saturated counter below the threshold.
    for (int i = 0; i < 2; i++) begin
      predict('h40, r_pt, r_ptgt);
      drive(0, 1, 1, 0, 0, 'h40, 32'h20, 32'd0, r_pt, r_ptgt, 'h40);
      settle_check();
      if (i == 0) begin
        check("nt_pcsel", 32'(PcSel), 32'd1);
        check("nt_brpc", BrPC, 32'h44);
      end
      tick();
    end
    idle('h40);
    check("nt_pred", 32'(F_PredTaken), 32'd0);
    tick();

    // JALR clears bit 0 of its target.
    drive(0, 1, 0, 0, 1, 'h40, 32'd0, 32'h87, 1, 32'h80, 'h40);
    settle_check();
    check("jalr_pcsel", 32'(PcSel), 32'd1);
    check("jalr_brpc", BrPC, 32'h86);
    tick();

    // 0x40 and 0x80 share index 0: allocating 0x80 evicts 0x40.
    drive(0, 1, 0, 1, 0, 'h80, 32'h10, 32'd0, 0, 32'd0, 'h80);
    settle_check();
    tick();
    idle('h40);
    check("evict_old", 32'(F_PredTaken), 32'd0);
    tick();
    idle('h80);
    check("evict_new", 32'(F_PredTaken), 32'd1);
    check("evict_tgt", F_PredTarget, 32'h90);
    tick();

    // Reset wins over a concurrent update.
    drive(1, 1, 0, 1, 0, 'h80, 32'h10, 32'd0, 0, 32'd0, 'h80);
    settle_check();
    tick();
    idle('h80);
    check("rst_upd_pred", 32'(F_PredTaken), 32'd0);
    check("rst_upd_br", 32'(BrCount), 32'd0);
    check("rst_upd_miss", 32'(MissCount), 32'd0);
    tick();

    // Randomized traffic over a small PC pool so entries hit, alias and evict.
    for (int c = 0; c < 4000; c++) begin
      r_pc   = $urandom_range(0, 31) * 4;
      r_kind = $urandom_range(0, 3);
      predict(r_pc, r_pt, r_ptgt);
      if ($urandom_range(0, 3) == 0) begin
        r_pt   = 1'($urandom_range(0, 1));
        r_ptgt = $urandom_range(0, 511);
      end
      r_imm = 32'($urandom_range(0, 127) * 4) - 32'd256;
      r_alu = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 511));
      r_fpc = ($urandom_range(0, 3) == 0) ? r_pc
                                          : $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            r_kind == 1, r_kind == 2, r_kind == 3, r_pc, r_imm, r_alu, r_pt, r_ptgt, r_fpc);
      settle_check();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
